uart_bus_regfile: RTL and testbench
===================================

// Module: uart_bus_regfile
// PURPOSE
//  Responder end of the uart2bus internal bus: arbitrates int_req against a
//  local hardware port, grants one master at a time, holds a byte register bank.
//  Sits below the UART bridge; supplies configuration bytes to the VESA/CA core.
// PARAMETERS
//  NUM_REGS   16       register count; power of 2, 2..256
//  BASE_ADDR  16'h0000 first bus address of the window; NUM_REGS-aligned
//  IDX_W      4        log2(NUM_REGS); sets the loc_addr width
// PORTS
//  clock        in   1             system clock, rising edge
//  reset        in   1             async reset, active high
//  int_address  in   16            UART-side byte address
//  int_wr_data  in   8             UART-side write data
//  int_write    in   1             UART-side write strobe, 1 cycle
//  int_read     in   1             UART-side read strobe, 1 cycle
//  int_rd_data  out  8             UART-side read data
//  int_req      in   1             UART-side bus request
//  int_gnt      out  1             UART-side bus grant
//  loc_req      in   1             local-port request
//  loc_gnt      out  1             local-port grant
//  loc_addr     in   IDX_W         local register index
//  loc_wr_data  in   8             local write data
//  loc_write    in   1             local write strobe
//  loc_rd_data  out  8             local read data, combinational from regs[loc_addr]
//  regs_flat    out  NUM_REGS*8    all registers; reg i at [8i+7:8i]
//  bus_err      out  1             sticky: out-of-window or ungranted UART access
// BEHAVIOUR
//  - Reset: regs=0, int_gnt=0, loc_gnt=0, int_rd_data=0, bus_err=0, state IDLE,
//    last_served=LOC. Async: grants drop immediately, even mid-transaction.
//  - Arbiter FSM, states IDLE, GNT_UART, GNT_LOC; grants are registered.
//    IDLE: int_req & loc_req -> grant the master not last served; otherwise
//    grant the sole requester; neither -> stay IDLE.
//    GNT_x: hold while x_req=1. When x_req=0: go to the other grant if the other
//    master requests, else IDLE. Update last_served=x.
//  - Grant latency: request seen in cycle N -> gnt=1 in cycle N+1.
//  - Grants are mutually exclusive in every cycle. No simultaneous writes occur.
//  - Window hit: BASE_ADDR <= int_address < BASE_ADDR+NUM_REGS.
//    Index = int_address[IDX_W-1:0].
//  - UART write: int_write & int_gnt & hit -> reg updated at that clock edge.
//  - UART read: int_read in cycle N -> int_rd_data valid in cycle N+1.
//    Holds that value until the next int_read. A miss returns 8'h00.
//  - bus_err sets when int_write|int_read occurs with (!int_gnt | !hit).
//    A write that sets bus_err is discarded. bus_err clears only on reset.
//  - Local write: loc_write & loc_gnt -> reg updated. Local writes without
//    loc_gnt are ignored silently.
//  - int_write & int_read asserted in the same cycle: the write takes effect and
//    the read returns the pre-write value.
// CONFIGURATION
//  REGFILE_LOCK_EN defined: reg NUM_REGS-1 is the LOCK register.
//    While LOCK[0]=1, UART writes to regs 0..NUM_REGS-2 are dropped and bus_err
//    is not set. LOCK itself stays UART-writable. Local writes are unaffected.
//  REGFILE_LOCK_EN undefined: reg NUM_REGS-1 is an ordinary register.
// STRUCTURE
//  Package uart_bus_pkg:
//    - arbiter state enum {IDLE, GNT_UART, GNT_LOC}
//    - last_served encoding
//    - RD_MISS_DATA=8'h00
//  Sub-module uart_bus_arb: the 2-master round-robin grant FSM.
//  The top holds the register array, address decode, read register and bus_err.
// TESTING
//  1 Assert reset mid-grant -> int_gnt, loc_gnt, int_rd_data, bus_err, regs_flat
//    all read 0 with no clock edge.
//  2 int_req=1; after grant, write 8'h5A to BASE+3; then int_read at BASE+3 ->
//    int_rd_data=8'h5A one cycle after int_read; regs_flat[31:24]=8'h5A.
//  3 int_req & loc_req both rise in the same cycle after reset -> int_gnt first.
//    Drop int_req -> loc_gnt=1 on the next cycle with no IDLE gap.
//    Re-raise int_req -> UART is served after loc_req drops.
//  4 Granted read at BASE+NUM_REGS -> int_rd_data=8'h00, bus_err=1.
//    Granted write to the same address -> regs_flat unchanged.
//  5 int_write to BASE+0 with int_gnt=0 (local granted) -> reg0 unchanged,
//    bus_err=1.
//  6 REGFILE_LOCK_EN: UART writes LOCK=8'h01, then writes reg0=8'hFF -> reg0
//    stays 0, bus_err=0. Local write reg0=8'h33 -> 8'h33. UART writes LOCK=0,
//    then reg0=8'hFF -> 8'hFF.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the uart2bus responder: arbiter states,
// last-served encoding and the data returned on a read miss.
package uart_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGntUart,
    StGntLoc
  } arb_state_e;

  typedef enum logic {
    SrvUart,
    SrvLoc
  } served_e;

  localparam logic [7:0] RD_MISS_DATA = 8'h00;

endpackage

// File: rtl/uart_bus_regfile_if.sv
// UART-side internal bus of the uart2bus bridge: request/grant handshake plus
// byte-wide address/data strobes.
interface uart_bus_regfile_if;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write;
  logic        int_read;
  logic [7:0]  int_rd_data;
  logic        int_req;
  logic        int_gnt;

  modport master (
    output int_address, int_wr_data, int_write, int_read, int_req,
    input  int_rd_data, int_gnt
  );

  modport slave (
    input  int_address, int_wr_data, int_write, int_read, int_req,
    output int_rd_data, int_gnt
  );
endinterface

// File: rtl/uart_bus_arb.sv
// Two-master round-robin grant FSM (UART vs local port). Grants are decoded
// straight from the state register, so they are glitch-free and exclusive.
module uart_bus_arb
  import uart_bus_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic int_req,
  input  logic loc_req,
  output logic int_gnt,
  output logic loc_gnt
);

  arb_state_e state_q, state_d;
  served_e    last_q, last_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= SrvLoc;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (int_req && loc_req) begin
          state_d = (last_q == SrvLoc) ? StGntUart : StGntLoc;
        end else if (int_req) begin
          state_d = StGntUart;
        end else if (loc_req) begin
          state_d = StGntLoc;
        end
      end
      StGntUart: begin
        if (!int_req) begin
          last_d  = SrvUart;
          state_d = loc_req ? StGntLoc : StIdle;
        end
      end
      StGntLoc: begin
        if (!loc_req) begin
          last_d  = SrvLoc;
          state_d = int_req ? StGntUart : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign int_gnt = (state_q == StGntUart);
  assign loc_gnt = (state_q == StGntLoc);

endmodule

// File: rtl/uart_bus_regfile.sv
// Responder end of the uart2bus internal bus: arbitrated byte register bank.
// Optional REGFILE_LOCK_EN makes the top register a UART write-lock.
module uart_bus_regfile
  import uart_bus_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_bus_regfile_if.slave     bus,
  input  logic                  loc_req,
  output logic                  loc_gnt,
  input  logic [IDX_W-1:0]      loc_addr,
  input  logic [7:0]            loc_wr_data,
  input  logic                  loc_write,
  output logic [7:0]            loc_rd_data,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  bus_err
);

  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       rd_data_q, rd_data_d;
  logic             bus_err_q, bus_err_d;
  logic [IDX_W-1:0] idx;
  logic             hit, locked, int_we, loc_we;

  uart_bus_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .int_req (bus.int_req),
    .loc_req (loc_req),
    .int_gnt (bus.int_gnt),
    .loc_gnt (loc_gnt)
  );

  // Window is NUM_REGS-aligned, so a tag compare on the upper bits is a full range check.
  assign idx = bus.int_address[IDX_W-1:0];
  assign hit = (bus.int_address[15:IDX_W] == BASE_ADDR[15:IDX_W]);

`ifdef REGFILE_LOCK_EN
  localparam logic [IDX_W-1:0] LOCK_IDX = IDX_W'(NUM_REGS - 1);
  assign locked = regs_q[LOCK_IDX][0] && (idx != LOCK_IDX);
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    int_we    = bus.int_write && bus.int_gnt && hit && !locked;
    loc_we    = loc_write && loc_gnt;
    bus_err_d = bus_err_q | ((bus.int_write | bus.int_read) & (!bus.int_gnt | !hit));
    rd_data_d = rd_data_q;
    if (bus.int_read) begin
      rd_data_d = (bus.int_gnt && hit) ? regs_q[idx] : RD_MISS_DATA;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      rd_data_q <= 8'h00;
      bus_err_q <= 1'b0;
    end else begin
      if (int_we) begin
        regs_q[idx] <= bus.int_wr_data;
      end else if (loc_we) begin
        regs_q[loc_addr] <= loc_wr_data;
      end
      rd_data_q <= rd_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[8*i +: 8] = regs_q[i];
    end
  end

  assign loc_rd_data     = regs_q[loc_addr];
  assign bus.int_rd_data = rd_data_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_uart_bus_regfile.sv
// Directed self-checking bench for uart_bus_regfile (default parameters).
// Define REGFILE_LOCK_EN for both RTL and bench to exercise the lock register.
module tb_uart_bus_regfile;

  localparam int unsigned N    = 16;
  localparam logic [15:0] BASE = 16'h0000;

  logic           clock = 1'b0;
  logic           reset;
  logic           loc_req, loc_gnt, loc_write, bus_err;
  logic [3:0]     loc_addr;
  logic [7:0]     loc_wr_data, loc_rd_data;
  logic [N*8-1:0] regs_flat, exp_flat;

  int checks = 0;
  int errors = 0;

  uart_bus_regfile_if bus ();

  uart_bus_regfile #(
    .NUM_REGS  (N),
    .BASE_ADDR (BASE),
    .IDX_W     (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .loc_req     (loc_req),
    .loc_gnt     (loc_gnt),
    .loc_addr    (loc_addr),
    .loc_wr_data (loc_wr_data),
    .loc_write   (loc_write),
    .loc_rd_data (loc_rd_data),
    .regs_flat   (regs_flat),
    .bus_err     (bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [N*8-1:0] got, input logic [N*8-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic uart_op(input logic [15:0] addr, input logic [7:0] data, input logic wr,
                         input logic rd);
    bus.int_address = addr;
    bus.int_wr_data = data;
    bus.int_write   = wr;
    bus.int_read    = rd;
    tick();
    bus.int_write   = 1'b0;
    bus.int_read    = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.int_address = '0;
    bus.int_wr_data = '0;
    bus.int_write   = 1'b0;
    bus.int_read    = 1'b0;
    bus.int_req     = 1'b0;
    loc_req         = 1'b0;
    loc_addr        = '0;
    loc_wr_data     = '0;
    loc_write       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_int_gnt", {127'b0, bus.int_gnt}, '0);
    check("rst_loc_gnt", {127'b0, loc_gnt}, '0);
    check("rst_rd_data", {120'b0, bus.int_rd_data}, '0);
    check("rst_bus_err", {127'b0, bus_err}, '0);
    check("rst_regs", regs_flat, '0);

    // Granted write then read back.
    bus.int_req = 1'b1;
    tick();
    check("uart_gnt", {126'b0, bus.int_gnt, loc_gnt}, 128'b10);
    uart_op(BASE + 16'd3, 8'h5A, 1'b1, 1'b0);
    check("wr_reg3", {120'b0, regs_flat[31:24]}, 128'h5A);
    uart_op(BASE + 16'd3, 8'h00, 1'b0, 1'b1);
    check("rd_reg3", {120'b0, bus.int_rd_data}, 128'h5A);
    tick();
    check("rd_hold", {120'b0, bus.int_rd_data}, 128'h5A);
    check("no_err", {127'b0, bus_err}, '0);

    // Write and read together: read returns the pre-write value.
    uart_op(BASE + 16'd5, 8'h77, 1'b1, 1'b1);
    check("wr_rd_same_old", {120'b0, bus.int_rd_data}, 128'h00);
    check("wr_rd_same_reg", {120'b0, regs_flat[47:40]}, 128'h77);
    uart_op(BASE + 16'd5, 8'h00, 1'b0, 1'b1);
    check("rd_reg5", {120'b0, bus.int_rd_data}, 128'h77);

    // Out-of-window read and write while granted.
    exp_flat          = '0;
    exp_flat[31:24]   = 8'h5A;
    exp_flat[47:40]   = 8'h77;
    uart_op(BASE + 16'(N), 8'h00, 1'b0, 1'b1);
    check("miss_rd_data", {120'b0, bus.int_rd_data}, 128'h00);
    check("miss_rd_err", {127'b0, bus_err}, 128'h1);
    uart_op(BASE + 16'(N), 8'hAA, 1'b1, 1'b0);
    check("miss_wr_regs", regs_flat, exp_flat);

    // Reset mid-grant clears everything without a clock edge.
    uart_op(BASE + 16'd3, 8'h00, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    check("async_int_gnt", {127'b0, bus.int_gnt}, '0);
    check("async_loc_gnt", {127'b0, loc_gnt}, '0);
    check("async_rd_data", {120'b0, bus.int_rd_data}, '0);
    check("async_bus_err", {127'b0, bus_err}, '0);
    check("async_regs", regs_flat, '0);
    bus.int_req = 1'b0;
    tick();
    reset = 1'b0;

    // Simultaneous requests after reset: UART first, then local with no idle gap.
    bus.int_req = 1'b1;
    loc_req     = 1'b1;
    tick();
    check("both_uart_first", {126'b0, bus.int_gnt, loc_gnt}, 128'b10);
    bus.int_req = 1'b0;
    tick();
    check("handover_loc", {126'b0, bus.int_gnt, loc_gnt}, 128'b01);

    // UART write while local holds the bus.
    uart_op(BASE, 8'h11, 1'b1, 1'b0);
    check("ungnt_wr_reg0", {120'b0, regs_flat[7:0]}, '0);
    check("ungnt_wr_err", {127'b0, bus_err}, 128'h1);

    // Local write and combinational local read.
    loc_addr    = 4'd2;
    loc_wr_data = 8'hC3;
    loc_write   = 1'b1;
    tick();
    loc_write   = 1'b0;
    check("loc_wr_reg2", {120'b0, regs_flat[23:16]}, 128'hC3);
    check("loc_rd_reg2", {120'b0, loc_rd_data}, 128'hC3);

    bus.int_req = 1'b1;
    tick();
    check("loc_held", {126'b0, bus.int_gnt, loc_gnt}, 128'b01);
    loc_req = 1'b0;
    tick();
    check("back_to_uart", {126'b0, bus.int_gnt, loc_gnt}, 128'b10);

    // Local write without grant is ignored.
    loc_addr    = 4'd4;
    loc_wr_data = 8'h99;
    loc_write   = 1'b1;
    tick();
    loc_write   = 1'b0;
    check("loc_ungnt_reg4", {120'b0, regs_flat[39:32]}, '0);

`ifdef REGFILE_LOCK_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("lock_start_gnt", {126'b0, bus.int_gnt, loc_gnt}, 128'b10);
    uart_op(BASE + 16'(N - 1), 8'h01, 1'b1, 1'b0);
    uart_op(BASE, 8'hFF, 1'b1, 1'b0);
    check("lock_reg0", {120'b0, regs_flat[7:0]}, '0);
    check("lock_no_err", {127'b0, bus_err}, '0);
    bus.int_req = 1'b0;
    loc_req     = 1'b1;
    tick();
    check("lock_loc_gnt", {126'b0, bus.int_gnt, loc_gnt}, 128'b01);
    loc_addr    = 4'd0;
    loc_wr_data = 8'h33;
    loc_write   = 1'b1;
    tick();
    loc_write   = 1'b0;
    check("lock_loc_wr", {120'b0, regs_flat[7:0]}, 128'h33);
    loc_req     = 1'b0;
    bus.int_req = 1'b1;
    tick();
    uart_op(BASE + 16'(N - 1), 8'h00, 1'b1, 1'b0);
    uart_op(BASE, 8'hFF, 1'b1, 1'b0);
    check("unlock_reg0", {120'b0, regs_flat[7:0]}, 128'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
